// File: rtl/div_sel_ctrl.sv
// div_sel_ctrl: glitch-free clock-select controller for the divider outputs.
// A ratio change first waits for the active source to go low. The output is
// then parked low for at least MIN_PARK cycles. Handover to the new source
// happens only while that source is low, so clk_out never shows a truncated
// high phase. A wait counter aborts the switch to "off" if a source stalls.
module div_sel_ctrl #(
  parameter int MIN_PARK = 2,    // 1..15
  parameter int TIMEOUT  = 255   // fits the 8-bit wait counter
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       div4,
  input  logic       div8,
  input  logic       div80,
  input  logic [1:0] req_sel,
  input  logic       req_valid,
  output logic       req_ready,
  output logic [1:0] cur_sel,
  output logic       clk_out,
  output logic       done,
  output logic       err,
  inout  wire        VDD,
  inout  wire        VSS
);

  localparam logic [3:0] PARK_LAST = 4'(MIN_PARK - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_OLD = 2'd1,
    PARK     = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [1:0] tgt, tgt_n, cur_sel_n;
  logic       clk_out_n, done_n, err_n;
  logic [7:0] wait_cnt, wait_cnt_n;
  logic [3:0] park_cnt, park_cnt_n;

  // Source levels indexed by select code; code 0 is the constant-low "off".
  logic [3:0] src_vec;
  logic       src_cur, src_tgt, timeout;

  // Power pins carry no logic; tie them off into a deliberately unused net.
  logic unused_pwr;
  assign unused_pwr = VDD & VSS;

  assign src_vec = {div80, div8, div4, 1'b0};
  assign src_cur = src_vec[cur_sel];
  assign src_tgt = src_vec[tgt];
  assign timeout = (wait_cnt == WAIT_LAST);

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state    <= RUN;
      tgt      <= 2'd0;
      cur_sel  <= 2'd0;
      clk_out  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= 8'd0;
      park_cnt <= 4'd0;
    end else begin
      state    <= state_n;
      tgt      <= tgt_n;
      cur_sel  <= cur_sel_n;
      clk_out  <= clk_out_n;
      done     <= done_n;
      err      <= err_n;
      wait_cnt <= wait_cnt_n;
      park_cnt <= park_cnt_n;
    end
  end

  // Next-state, handshake and next-output logic for the switch sequence.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_n    = state;
    tgt_n      = tgt;
    cur_sel_n  = cur_sel;
    clk_out_n  = clk_out;
    done_n     = 1'b0;
    err_n      = err;
    wait_cnt_n = wait_cnt;
    park_cnt_n = park_cnt;
    req_ready  = 1'b0;

    case (state)
      RUN: begin
        req_ready = 1'b1;
        clk_out_n = src_cur;
        if (req_valid) begin
          tgt_n      = req_sel;
          err_n      = 1'b0;
          wait_cnt_n = 8'd0;
          if (req_sel == cur_sel) done_n  = 1'b1;
          else                    state_n = WAIT_OLD;
        end
      end

      WAIT_OLD: begin
        wait_cnt_n = wait_cnt + 8'd1;
        if (timeout) begin
          // Old source never fell: give up and switch the output off.
          cur_sel_n = 2'd0;
          clk_out_n = 1'b0;
          err_n     = 1'b1;
          done_n    = 1'b1;
          state_n   = RUN;
        end else if (!src_cur) begin
          clk_out_n  = 1'b0;
          park_cnt_n = 4'd0;
          state_n    = PARK;
        end else begin
          clk_out_n = src_cur;
        end
      end

      PARK: begin
        clk_out_n  = 1'b0;
        wait_cnt_n = wait_cnt + 8'd1;
        if (park_cnt != 4'hF) park_cnt_n = park_cnt + 4'd1;
        // Handover wins over a coincident timeout.
        if (park_cnt >= PARK_LAST && !src_tgt) begin
          cur_sel_n = tgt;
          done_n    = 1'b1;
          state_n   = RUN;
        end else if (timeout) begin
          cur_sel_n = 2'd0;
          err_n     = 1'b1;
          done_n    = 1'b1;
          state_n   = RUN;
        end
      end

      default: state_n = RUN;
    endcase
  end

endmodule

// File: tb/tb_div_sel_ctrl.sv
// tb_div_sel_ctrl: randomized bench for div_sel_ctrl. The divider levels are
// pure functions of the cycle index, so the reference model can look ahead
// and compute, for each request, the cycle the old source first falls, the
// cycle handover becomes legal, or the cycle the wait budget runs out.
module tb_div_sel_ctrl;

  localparam int MIN_PARK = 2;
  localparam int TIMEOUT  = 255;

  logic       clk = 1'b0;
  logic       reset, div4, div8, div80, req_valid;
  logic [1:0] req_sel;
  logic       req_ready, clk_out, done, err;
  logic [1:0] cur_sel;
  wire        vdd_w = 1'b1;
  wire        vss_w = 1'b0;

  always #5 clk = ~clk;

  div_sel_ctrl #(.MIN_PARK(MIN_PARK), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .div4      (div4),
    .div8      (div8),
    .div80     (div80),
    .req_sel   (req_sel),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .cur_sel   (cur_sel),
    .clk_out   (clk_out),
    .done      (done),
    .err       (err),
    .VDD       (vdd_w),
    .VSS       (vss_w)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_e = 0;
  int         hi_run = 0;
  int         lat;
  int         ph4 = 0, ph8 = 0, ph80 = 0;
  bit         stuck4 = 0, stuck80 = 0;
  logic       last_rst;
  logic [1:0] mcur = 2'd0;
  logic       merr = 1'b0;

  // Level of source s during cycle c.
  function automatic logic src_at(input logic [1:0] s, input int c);
    case (s)
      2'd1:    return stuck4  ? 1'b1 : ((((c + ph4)  / 2)  % 2) != 0);
      2'd2:    return ((((c + ph8) / 4) % 2) != 0);
      2'd3:    return stuck80 ? 1'b1 : ((((c + ph80) / 40) % 2) != 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_divs();
    div4  = src_at(2'd1, cyc);
    div8  = src_at(2'd2, cyc);
    div80 = src_at(2'd3, cyc);
  endtask

  // Advance one clock; afterwards outputs reflect edge last_e. Also watches
  // clk_out for any high pulse shorter than the shortest source high phase.
  task automatic step();
    last_rst = reset;
    last_e   = cyc;
    @(posedge clk);
    #1;
    cyc++;
    drive_divs();
    if (last_rst !== 1'b1) begin
      hi_run = 0;
    end else if (clk_out === 1'b1) begin
      hi_run++;
    end else begin
      if (hi_run > 0) begin
        checks++;
        if (hi_run < 2) begin
          errors++;
          $display("FAIL glitch edge %0d high_len=%0d want>=2", last_e, hi_run);
        end
      end
      hi_run = 0;
    end
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if (clk_out !== src_at(mcur, last_e) || done !== 1'b0 || req_ready !== 1'b1 ||
          cur_sel !== mcur || err !== merr) begin
        errors++;
        $display("FAIL idle edge %0d clk_out=%b exp=%b done=%b ready=%b cur_sel=%0d exp=%0d err=%b exp=%b",
                 last_e, clk_out, src_at(mcur, last_e), done, req_ready, cur_sel, mcur, err, merr);
      end
    end
  endtask

  // Issue one request and check every edge through completion plus two.
  // rst_park>0 drops reset rst_park cycles after the old source falls.
  task automatic do_req(input logic [1:0] sel, input int rst_park, output int lat_o);
    int         t, a, w, h, endc, last_follow;
    logic [1:0] old_s, new_s, exp_cur;
    logic       errf, exp_clk, exp_done, exp_ready, exp_err;
    old_s = mcur;
    t     = cyc;
    w     = -1;
    h     = -1;
    a     = t + TIMEOUT;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_req cyc %0d got=%b want=1", cyc, req_ready);
    end
    if (sel == old_s) begin
      endc = t; new_s = old_s; errf = 1'b0; last_follow = t + 1000;
    end else begin
      for (int c = t + 1; c < a; c++)
        if (!src_at(old_s, c)) begin w = c; break; end
      if (w >= 0)
        for (int c = w + MIN_PARK; c <= a; c++)
          if (!src_at(sel, c)) begin h = c; break; end
      if (h >= 0) begin endc = h; new_s = sel;  errf = 1'b0; end
      else        begin endc = a; new_s = 2'd0; errf = 1'b1; end
      last_follow = (w >= 0) ? w : a - 1;
    end
    req_sel   = sel;
    req_valid = 1'b1;
    for (int c = t; c <= endc + 2; c++) begin
      if (rst_park > 0 && w >= 0 && c == w + rst_park && c < endc) reset = 1'b0;
      step();
      req_valid = 1'b0;
      if (reset === 1'b0) begin
        checks++;
        if (clk_out !== 1'b0 || cur_sel !== 2'd0 || done !== 1'b0 || err !== 1'b0 ||
            req_ready !== 1'b1) begin
          errors++;
          $display("FAIL reset_mid_switch edge %0d clk_out=%b cur_sel=%0d done=%b err=%b ready=%b want 0/0/0/0/1",
                   last_e, clk_out, cur_sel, done, err, req_ready);
        end
        reset = 1'b1;
        mcur  = 2'd0;
        merr  = 1'b0;
        lat_o = -1;
        return;
      end
      if (c <= endc) exp_clk = (c <= last_follow) ? src_at(old_s, c) : 1'b0;
      else           exp_clk = src_at(new_s, c);
      exp_cur   = (c < endc) ? old_s : new_s;
      exp_done  = (c == endc);
      exp_ready = (c >= endc);
      exp_err   = (c < endc) ? 1'b0 : errf;
      checks++;
      if (clk_out !== exp_clk || cur_sel !== exp_cur || done !== exp_done ||
          req_ready !== exp_ready || err !== exp_err) begin
        errors++;
        $display("FAIL switch %0d->%0d edge %0d clk_out=%b/%b cur_sel=%0d/%0d done=%b/%b ready=%b/%b err=%b/%b",
                 old_s, sel, c, clk_out, exp_clk, cur_sel, exp_cur, done, exp_done,
                 req_ready, exp_ready, err, exp_err);
      end
    end
    mcur  = new_s;
    merr  = errf;
    lat_o = endc - t;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (clk_out !== 1'b0 || cur_sel !== 2'd0 || req_ready !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold edge %0d clk_out=%b cur_sel=%0d ready=%b err=%b done=%b",
                 last_e, clk_out, cur_sel, req_ready, err, done);
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if (clk_out !== 1'b0 || cur_sel !== 2'd0 || req_ready !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release edge %0d clk_out=%b cur_sel=%0d ready=%b err=%b done=%b",
               last_e, clk_out, cur_sel, req_ready, err, done);
    end
    mcur = 2'd0;
    merr = 1'b0;
  endtask

  task automatic test_off_to_div4();
    ph4 = int'($urandom_range(0, 3));
    run_idle(2);
    do_req(2'd1, 0, lat);
    checks++;
    if (lat + 1 > MIN_PARK + 4) begin
      errors++;
      $display("FAIL off_to_div4_latency got=%0d want<=%0d", lat + 1, MIN_PARK + 4);
    end
    checks++;
    if (cur_sel !== 2'd1) begin
      errors++;
      $display("FAIL off_to_div4_sel got=%0d want=1", cur_sel);
    end
    run_idle(8);
  endtask

  task automatic test_div4_to_div80();
    ph80 = int'($urandom_range(0, 79));
    for (int i = 0; i < 4 && !src_at(2'd1, cyc); i++) run_idle(1);
    do_req(2'd3, 0, lat);
    checks++;
    if (cur_sel !== 2'd3) begin
      errors++;
      $display("FAIL div4_to_div80_sel got=%0d want=3", cur_sel);
    end
    run_idle(10);
  endtask

  task automatic test_same_sel();
    ph8 = int'($urandom_range(0, 7));
    do_req(2'd2, 0, lat);
    run_idle(9);
    do_req(2'd2, 0, lat);
    checks++;
    if (lat != 0 || cur_sel !== 2'd2) begin
      errors++;
      $display("FAIL same_sel latency=%0d cur_sel=%0d want 0/2", lat, cur_sel);
    end
    run_idle(6);
  endtask

  task automatic test_timeout();
    do_req(2'd0, 0, lat);
    stuck4 = 1'b1;
    run_idle(2);
    do_req(2'd1, 0, lat);
    checks++;
    if (lat != TIMEOUT || err !== 1'b1 || cur_sel !== 2'd0 || clk_out !== 1'b0) begin
      errors++;
      $display("FAIL timeout latency=%0d err=%b cur_sel=%0d clk_out=%b want %0d/1/0/0",
               lat, err, cur_sel, clk_out, TIMEOUT);
    end
    stuck4 = 1'b0;
    run_idle(3);
    do_req(2'd2, 0, lat);
    checks++;
    if (err !== 1'b0 || cur_sel !== 2'd2) begin
      errors++;
      $display("FAIL err_clear err=%b cur_sel=%0d want 0/2", err, cur_sel);
    end
    run_idle(4);
  endtask

  task automatic test_reset_mid_park();
    stuck80 = 1'b1;
    do_req(2'd3, 2, lat);
    checks++;
    if (lat != -1) begin
      errors++;
      $display("FAIL reset_mid_park_reached got=%0d want=-1", lat);
    end
    stuck80 = 1'b0;
    run_idle(3);
    do_req(2'd3, 0, lat);
    checks++;
    if (lat < 0 || cur_sel !== 2'd3 || err !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_req latency=%0d cur_sel=%0d err=%b want >=0/3/0", lat, cur_sel, err);
    end
    run_idle(4);
  endtask

  task automatic test_back_to_back();
    logic [1:0] sel;
    for (int i = 0; i < 14; i++) begin
      if (mcur != 2'd1) ph4  = int'($urandom_range(0, 3));
      if (mcur != 2'd2) ph8  = int'($urandom_range(0, 7));
      if (mcur != 2'd3) ph80 = int'($urandom_range(0, 79));
      sel = 2'($urandom_range(0, 3));
      do_req(sel, 0, lat);
      run_idle(int'($urandom_range(0, 5)));
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_sel   = 2'd0;
    last_rst  = 1'b0;
    drive_divs();
    test_reset();
    test_off_to_div4();
    test_div4_to_div80();
    test_same_sel();
    test_timeout();
    test_reset_mid_park();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sel_ctrl.md
Name: div_sel_ctrl

Overview:
Glitch-free clock-select controller for the divider outputs (div4, div8, div80). It accepts a ratio-change request over a valid/ready handshake and waits until the active source is low. It then parks the output low and hands over to the new source only while that source is low, so clk_out never carries a truncated high phase. A timeout forces the output off if a source stops toggling.

Parameters:
MIN_PARK, 2, minimum cycles clk_out is held low in PARK before handover; legal range 1..15
TIMEOUT, 255, max cycles spent in WAIT_OLD+PARK before abort; 8-bit wait counter

Ports:
clk  input  1  system clock; all div inputs are registered in this domain
reset  input  1  synchronous, active-low
div4  input  1  divide-by-4 level from divider
div8  input  1  divide-by-8 level from divider
div80  input  1  divide-by-80 level from divider
req_sel  input  2  requested source: 0=off (constant 0), 1=div4, 2=div8, 3=div80
req_valid  input  1  request strobe
req_ready  output  1  high only in RUN
cur_sel  output  2  source currently driving clk_out
clk_out  output  1  registered selected clock
done  output  1  one-cycle pulse when a request completes (success or abort)
err  output  1  sticky timeout flag; cleared on next accepted request
VDD  inout  1  power
VSS  inout  1  ground

Behaviour:
- Reset (reset==0 at posedge clk): state=RUN, cur_sel=0, clk_out=0, done=0, err=0, counters=0. Reset mid-switch aborts silently; no done pulse.
- src(s): 0 for s=0; otherwise div4/div8/div80. Level is sampled the same cycle it is used.
- RUN: clk_out <= src(cur_sel), 1-cycle latency. req_ready=1.
  - Accept on req_valid&req_ready: tgt<=req_sel, err<=0, wait_cnt<=0.
  - If req_sel==cur_sel: stay in RUN, done=1 next cycle, no disturbance to clk_out.
  - Else go to WAIT_OLD.
- WAIT_OLD: clk_out <= src(cur_sel); wait_cnt++.
  - When src(cur_sel)==0: clk_out<=0, park_cnt<=0, go to PARK.
  - cur_sel=0 therefore exits after 1 cycle.
- PARK: clk_out held 0; park_cnt++ (saturating); wait_cnt++.
  - Handover when park_cnt>=MIN_PARK-1 and src(tgt)==0: cur_sel<=tgt, clk_out<=0, done=1, go to RUN.
  - clk_out's first rising edge after handover is a full high phase of tgt.
- Timeout: if wait_cnt reaches TIMEOUT-1 in WAIT_OLD or PARK without handover, then next cycle: cur_sel<=0, clk_out<=0, err<=1, done=1, go to RUN.
- Priority: a handover and the timeout in the same cycle resolve as handover (no err).
- req_valid outside RUN is ignored; it is not queued. The requester holds valid until ready.
- Invariants:
  - clk_out high periods are never shorter than the active source's high phase.
  - No clk_out 0->1 occurs in WAIT_OLD->PARK or PARK->RUN cycles.
- done is exactly one cycle per accepted request.

Test Plan:
1. Reset with all div inputs toggling -> clk_out=0, cur_sel=0, req_ready=1, err=0 while reset low and 1 cycle after.
2. From off, request sel=1 with div4 at phase 2-high/2-low -> done ≤ MIN_PARK+4 cycles later; cur_sel=1; clk_out = div4 delayed 1 cycle; first high lasts 2 cycles.
3. Running div4, request sel=3 while div4 high -> clk_out stays high until the div4 fall, then low ≥2 cycles; handover only when div80 is low; no high pulse <2 cycles; cur_sel=3.
4. Running div8, request sel=2 -> done pulse next cycle, clk_out waveform unchanged, state remains RUN.
5. Request sel=1 with div4 stuck high, TIMEOUT=255 -> done and err=1 after 255 cycles in WAIT_OLD; cur_sel=0; clk_out=0. Next accepted request clears err.
6. Drop reset mid-PARK -> outputs return to reset values on that edge; no done pulse. A request after reset release completes normally.
